pa_ifu_ibuf_queue: RTL and testbench

Parametrised instruction buffer for the IFU: a circular queue of `DEPTH` half-word slots between the fetch/align stage and decode. Each cycle it accepts up to `CREATE_N` in-order creates and presents up to `RETIRE_N` oldest entries for in-order retire. It keeps per-slot clock gating on the payload and adds occupancy tracking, all-or-nothing create backpressure and flush.

---
 rtl/pa_ifu_ibuf_queue_pkg.sv | 35 +++
 rtl/gated_clk_cell.sv | 32 +++
 rtl/pa_ifu_ibuf_queue_slot.sv | 44 ++++
 rtl/pa_ifu_ibuf_queue.sv | 143 ++++++++++++++
 tb/tb_pa_ifu_ibuf_queue.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/pa_ifu_ibuf_queue_pkg.sv
// Shared definitions for the IFU instruction buffer.
// Holds the payload field layout, the default geometry and a helper that
// counts the contiguous run of ones starting at bit 0 (thermometer length).
package pa_ifu_ibuf_queue_pkg;

  // Payload layout: {acc_err, halt_info, pred_taken, inst}
  localparam int INST_LSB        = 0;
  localparam int INST_W          = 16;
  localparam int PRED_LSB        = INST_LSB + INST_W;
  localparam int PRED_W          = 2;
  localparam int HINFO_LSB       = PRED_LSB + PRED_W;
  localparam int TDT_HINFO_WIDTH = 15;
  localparam int ACC_ERR_BIT     = HINFO_LSB + TDT_HINFO_WIDTH;
  localparam int PAYLOAD_W_DEF   = ACC_ERR_BIT + 1;

  localparam int DEPTH_DEF    = 8;
  localparam int CREATE_N_DEF = 3;
  localparam int RETIRE_N_DEF = 2;

  // Length of the run of ones starting at bit 0, looking at the low n bits.
  function automatic int unsigned lead_ones(input logic [31:0] v, input int n);
    int unsigned ones;
    logic        run;
    ones = 0;
    run  = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i < n && run) begin
        if (v[i]) ones++;
        else      run = 1'b0;
      end
    end
    return ones;
  endfunction

endpackage

// File: rtl/gated_clk_cell.sv
// Latch-based integrated clock gate.
// Ports:
//   clk_in             free-running clock
//   global_en          chip-level clock enable; gates everything when low
//   module_en          module ICG disable (1 keeps the clock running)
//   local_en           per-instance activity enable
//   external_en        forces the clock on
//   pad_yy_icg_scan_en scan-mode override
//   clk_out            gated clock
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);

  logic clk_en_bf_latch;
  logic clk_en_lat;

  assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

  // Transparent while the clock is low so the enable cannot glitch clk_out.
  always_latch begin
    if (!clk_in) clk_en_lat <= clk_en_bf_latch | pad_yy_icg_scan_en;
  end

  assign clk_out = clk_in & clk_en_lat;

endmodule

// File: rtl/pa_ifu_ibuf_queue_slot.sv
// One instruction-buffer slot: a payload register behind its own clock gate.
// The payload has no reset; validity is tracked by the parent.
// Ports:
//   forever_cpuclk      core clock
//   cp0_yy_clk_en, cp0_ifu_icg_en, pad_yy_icg_scan_en  ICG controls
//   wr_en               slot is written by a create this cycle
//   warm_up             zero the payload (a same-cycle write wins)
//   wr_data             create payload
//   data                stored payload
module pa_ifu_ibuf_slot
  import pa_ifu_ibuf_queue_pkg::*;
#(
  parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
  input  logic                 forever_cpuclk,
  input  logic                 cp0_yy_clk_en,
  input  logic                 cp0_ifu_icg_en,
  input  logic                 pad_yy_icg_scan_en,
  input  logic                 wr_en,
  input  logic                 warm_up,
  input  logic [PAYLOAD_W-1:0] wr_data,
  output logic [PAYLOAD_W-1:0] data
);

  logic slot_clk;

  gated_clk_cell u_icg (
    .clk_in             (forever_cpuclk),
    .global_en          (cp0_yy_clk_en),
    .module_en          (cp0_ifu_icg_en),
    .local_en           (wr_en | warm_up),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (slot_clk)
  );

  // The enables are repeated here so the slot holds its value when the
  // gate is forced open (module ICG disabled or scan).
  always_ff @(posedge slot_clk) begin
    if (wr_en)        data <= wr_data;
    else if (warm_up) data <= '0;
  end

endmodule

// File: rtl/pa_ifu_ibuf_queue.sv
// IFU instruction buffer: circular queue of DEPTH half-word slots between
// fetch/align and decode. Up to CREATE_N in-order creates per cycle
// (all-or-nothing backpressure), up to RETIRE_N oldest entries presented
// and retired in order. Flush empties the queue; warm-up zeroes payloads.
// Ports:
//   forever_cpuclk, cpurst_b          clock, async active-low reset
//   cp0_yy_clk_en, cp0_ifu_icg_en, pad_yy_icg_scan_en  slot ICG controls
//   vec_ibuf_warm_up                  zero all payload registers
//   ibuf_flush_en                     empty the queue
//   ibuf_create_vld/data/rdy          create side
//   ibuf_retire_en                    retire request (thermometer)
//   ibuf_out_vld/data                 oldest RETIRE_N entries
//   ibuf_cnt, ibuf_empty, ibuf_full   occupancy
module pa_ifu_ibuf_queue
  import pa_ifu_ibuf_queue_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int CREATE_N  = CREATE_N_DEF,
  parameter int RETIRE_N  = RETIRE_N_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                          forever_cpuclk,
  input  logic                          cpurst_b,
  input  logic                          cp0_yy_clk_en,
  input  logic                          cp0_ifu_icg_en,
  input  logic                          pad_yy_icg_scan_en,
  input  logic                          vec_ibuf_warm_up,
  input  logic                          ibuf_flush_en,
  input  logic [CREATE_N-1:0]           ibuf_create_vld,
  input  logic [CREATE_N*PAYLOAD_W-1:0] ibuf_create_data,
  output logic                          ibuf_create_rdy,
  input  logic [RETIRE_N-1:0]           ibuf_retire_en,
  output logic [RETIRE_N-1:0]           ibuf_out_vld,
  output logic [RETIRE_N*PAYLOAD_W-1:0] ibuf_out_data,
  output logic [CNT_W-1:0]              ibuf_cnt,
  output logic                          ibuf_empty,
  output logic                          ibuf_full
);

  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     cnt;
  logic [DEPTH-1:0]     valid;
  logic [DEPTH-1:0]     valid_next;
  logic [DEPTH-1:0]     slot_wr_en;
  logic [PAYLOAD_W-1:0] slot_wr_data [DEPTH];
  logic [PAYLOAD_W-1:0] slot_q       [DEPTH];
  int unsigned          c_num;
  int unsigned          r_num;

  // Credit comes from the registered count only; a same-cycle retire
  // does not open room for a create.
  assign ibuf_create_rdy = (cnt <= CNT_W'(DEPTH - CREATE_N));
  assign ibuf_cnt        = cnt;
  assign ibuf_empty      = (cnt == '0);
  assign ibuf_full       = (cnt == CNT_W'(DEPTH));

  always_comb begin
    c_num = 0;
    if (ibuf_create_rdy && !ibuf_flush_en)
      c_num = lead_ones(32'(ibuf_create_vld), CREATE_N);
  end

  always_comb begin
    r_num = 0;
    if (!ibuf_flush_en)
      r_num = lead_ones(32'(ibuf_retire_en & ibuf_out_vld), RETIRE_N);
  end

  // Output window: slots head..head+RETIRE_N-1, data masked by valid.
  always_comb begin
    logic [PTR_W-1:0] idx;
    ibuf_out_vld  = '0;
    ibuf_out_data = '0;
    for (int k = 0; k < RETIRE_N; k++) begin
      idx = head + PTR_W'(k);
      ibuf_out_vld[k] = valid[idx];
      if (valid[idx]) ibuf_out_data[k*PAYLOAD_W +: PAYLOAD_W] = slot_q[idx];
    end
  end

  // Create port k lands in slot tail+k.
  always_comb begin
    logic [PTR_W-1:0] idx;
    slot_wr_en = '0;
    for (int s = 0; s < DEPTH; s++) slot_wr_data[s] = '0;
    for (int k = 0; k < CREATE_N; k++) begin
      idx = tail + PTR_W'(k);
      if (k < int'(c_num)) begin
        slot_wr_en[idx]   = 1'b1;
        slot_wr_data[idx] = ibuf_create_data[k*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  // Created and retired slots never overlap: creates only go to free slots.
  always_comb begin
    logic [PTR_W-1:0] idx;
    valid_next = valid;
    for (int k = 0; k < RETIRE_N; k++) begin
      idx = head + PTR_W'(k);
      if (k < int'(r_num)) valid_next[idx] = 1'b0;
    end
    valid_next = valid_next | slot_wr_en;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      valid <= '0;
    end else if (ibuf_flush_en) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      valid <= '0;
    end else begin
      head  <= head + PTR_W'(r_num);
      tail  <= tail + PTR_W'(c_num);
      cnt   <= cnt + CNT_W'(c_num) - CNT_W'(r_num);
      valid <= valid_next;
    end
  end

  for (genvar s = 0; s < DEPTH; s++) begin : g_slot
    pa_ifu_ibuf_slot #(
      .PAYLOAD_W (PAYLOAD_W)
    ) u_slot (
      .forever_cpuclk     (forever_cpuclk),
      .cp0_yy_clk_en      (cp0_yy_clk_en),
      .cp0_ifu_icg_en     (cp0_ifu_icg_en),
      .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
      .wr_en              (slot_wr_en[s]),
      .warm_up            (vec_ibuf_warm_up),
      .wr_data            (slot_wr_data[s]),
      .data               (slot_q[s])
    );
  end

endmodule

// File: tb/tb_pa_ifu_ibuf_queue.sv
// Bench for pa_ifu_ibuf_queue: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the buffer.
module tb_pa_ifu_ibuf_queue;
  import pa_ifu_ibuf_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int CN    = 3;
  localparam int RN    = 2;
  localparam int PW    = 34;

  logic             clk;
  logic             rst_n;
  logic             clk_en, icg_en, scan_en;
  logic             warm, flush;
  logic [CN-1:0]    create_vld;
  logic [CN*PW-1:0] create_data;
  logic             create_rdy;
  logic [RN-1:0]    retire_en;
  logic [RN-1:0]    out_vld;
  logic [RN*PW-1:0] out_data;
  logic [3:0]       cnt;
  logic             empty, full;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] q[$];

  pa_ifu_ibuf_queue #(
    .DEPTH(DEPTH), .CREATE_N(CN), .RETIRE_N(RN), .PAYLOAD_W(PW)
  ) dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (rst_n),
    .cp0_yy_clk_en      (clk_en),
    .cp0_ifu_icg_en     (icg_en),
    .pad_yy_icg_scan_en (scan_en),
    .vec_ibuf_warm_up   (warm),
    .ibuf_flush_en      (flush),
    .ibuf_create_vld    (create_vld),
    .ibuf_create_data   (create_data),
    .ibuf_create_rdy    (create_rdy),
    .ibuf_retire_en     (retire_en),
    .ibuf_out_vld       (out_vld),
    .ibuf_out_data      (out_data),
    .ibuf_cnt           (cnt),
    .ibuf_empty         (empty),
    .ibuf_full          (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rnd_pl();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[PW-1:0];
  endfunction

  task automatic check_outputs();
    int sz;
    logic [PW-1:0] ed;
    sz = q.size();
    chk("cnt",   64'(cnt),        64'(sz));
    chk("empty", 64'(empty),      64'(sz == 0));
    chk("full",  64'(full),       64'(sz == DEPTH));
    chk("rdy",   64'(create_rdy), 64'((DEPTH - sz) >= CN));
    for (int k = 0; k < RN; k++) begin
      ed = (k < sz) ? q[k] : '0;
      chk($sformatf("out_vld%0d", k),  64'(out_vld[k]), 64'(k < sz));
      chk($sformatf("out_data%0d", k), 64'(out_data[k*PW +: PW]), 64'(ed));
    end
  endtask

  // Reference behaviour of one clock edge, from the state before the edge.
  task automatic model_edge();
    int  c, r, sz;
    bit  rdy;
    sz  = q.size();
    rdy = (DEPTH - sz) >= CN;
    c = 0;
    r = 0;
    if (flush) begin
      q.delete();
    end else begin
      for (int k = 0; k < RN; k++)
        if (retire_en[k] && k < sz && r == k) r++;
      repeat (r) void'(q.pop_front());
      if (warm) foreach (q[i]) q[i] = '0;
      if (rdy)
        for (int k = 0; k < CN; k++)
          if (create_vld[k] && c == k) begin
            q.push_back(create_data[k*PW +: PW]);
            c++;
          end
    end
  endtask

  // Called at a negedge: drive, take the edge, then check at the next negedge.
  task automatic step(input logic [CN-1:0] cv, input logic [PW-1:0] d0,
                      input logic [PW-1:0] d1, input logic [PW-1:0] d2,
                      input logic [RN-1:0] re, input logic fl, input logic wu);
    create_vld  = cv;
    create_data = {d2, d1, d0};
    retire_en   = re;
    flush       = fl;
    warm        = wu;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    chk("cnt_le_depth", 64'(cnt <= DEPTH), 64'd1);
  endtask

  task automatic rnd_step(input int flush_odds, input int warm_odds);
    step(CN'($urandom_range(0, 7)), rnd_pl(), rnd_pl(), rnd_pl(),
         RN'($urandom_range(0, 3)),
         ($urandom_range(0, flush_odds - 1) == 0),
         ($urandom_range(0, warm_odds - 1) == 0));
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; icg_en = 1'b0; scan_en = 1'b0;
    warm = 1'b0; flush = 1'b0; create_vld = '0; create_data = '0; retire_en = '0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // idle after reset
    step(3'b000, '0, '0, '0, 2'b00, 0, 0);
    step(3'b000, '0, '0, '0, 2'b00, 0, 0);

    // basic creates
    step(3'b111, 34'h1111, 34'h2222, 34'h3333, 2'b00, 0, 0);
    chk("dir_cnt3", 64'(cnt), 64'd3);
    chk("dir_d0", 64'(out_data[0 +: PW]), 64'h1111);
    step(3'b011, 34'h4444, 34'h5555, 34'h9999, 2'b00, 0, 0);
    chk("dir_cnt5", 64'(cnt), 64'd5);
    chk("dir_d1", 64'(out_data[PW +: PW]), 64'h2222);

    // backpressure at cnt=6
    step(3'b001, 34'h6666, '0, '0, 2'b00, 0, 0);
    chk("dir_rdy0", 64'(create_rdy), 64'd0);
    step(3'b111, 34'h7777, 34'h8888, 34'h9999, 2'b00, 0, 0);
    chk("dir_hold6", 64'(cnt), 64'd6);
    step(3'b000, '0, '0, '0, 2'b11, 0, 0);
    chk("dir_cnt4", 64'(cnt), 64'd4);
    chk("dir_rdy1", 64'(create_rdy), 64'd1);
    step(3'b000, '0, '0, '0, 2'b11, 0, 0);
    step(3'b000, '0, '0, '0, 2'b11, 0, 0);
    chk("dir_drained", 64'(empty), 64'd1);

    // wrap-around
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) step(3'b111, rnd_pl(), rnd_pl(), rnd_pl(), 2'b11, 0, 0);
      else            step(3'b000, '0, '0, '0, 2'b11, 0, 0);
    end

    // flush beats create and retire
    repeat (4) step(3'b000, '0, '0, '0, 2'b11, 0, 0);
    step(3'b111, rnd_pl(), rnd_pl(), rnd_pl(), 2'b00, 0, 0);
    step(3'b011, rnd_pl(), rnd_pl(), rnd_pl(), 2'b00, 0, 0);
    chk("pre_flush_cnt5", 64'(cnt), 64'd5);
    step(3'b111, rnd_pl(), rnd_pl(), rnd_pl(), 2'b11, 1, 0);
    chk("flush_cnt0", 64'(cnt), 64'd0);
    chk("flush_vld0", 64'(out_vld), 64'd0);

    // retire request wider than occupancy
    step(3'b001, 34'h0abcd, '0, '0, 2'b00, 0, 0);
    step(3'b000, '0, '0, '0, 2'b11, 0, 0);
    chk("single_retire_cnt0", 64'(cnt), 64'd0);

    // warm-up keeps occupancy, zeroes payload, same-cycle create wins
    step(3'b111, rnd_pl(), rnd_pl(), rnd_pl(), 2'b00, 0, 0);
    step(3'b000, '0, '0, '0, 2'b00, 0, 1);
    chk("warm_cnt3", 64'(cnt), 64'd3);
    chk("warm_vld", 64'(out_vld), 64'd3);
    step(3'b011, rnd_pl(), rnd_pl(), '0, 2'b00, 0, 1);
    repeat (3) step(3'b000, '0, '0, '0, 2'b11, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) rnd_step(32, 32);

    // asynchronous reset mid-operation
    repeat (3) step(3'b111, rnd_pl(), rnd_pl(), rnd_pl(), 2'b01, 0, 0);
    #2 rst_n = 1'b0;
    q.delete();
    #1 check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b111, rnd_pl(), rnd_pl(), rnd_pl(), 2'b00, 0, 0);
    chk("post_reset_cnt3", 64'(cnt), 64'd3);
    for (int i = 0; i < 100; i++) rnd_step(16, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
